// File: rtl/router_1_pkg.sv
// Shared router_1 definitions: crossbar port codes and round-robin pointer type.
package router_1_pkg;

    localparam logic [2:0] PORT_L    = 3'b000;
    localparam logic [2:0] PORT_N    = 3'b001;
    localparam logic [2:0] PORT_E    = 3'b010;
    localparam logic [2:0] PORT_W    = 3'b011;
    localparam logic [2:0] PORT_S    = 3'b100;
    localparam logic [2:0] PORT_NONE = 3'b111;

    typedef enum logic [1:0] {
        RR_W = 2'd0,
        RR_S = 2'd1,
        RR_L = 2'd2
    } rr_t;

    function automatic rr_t rr_after(input rr_t p);
        unique case (p)
            RR_W:    rr_after = RR_S;
            RR_S:    rr_after = RR_L;
            default: rr_after = RR_W;
        endcase
    endfunction

endpackage

// File: rtl/router_1_rr_pick.sv
// Round-robin requester pick: first request at or after ptr, circular W->S->L.
module router_1_rr_pick
    import router_1_pkg::*;
(
    input  logic [2:0] req,
    input  rr_t        ptr,
    output logic [2:0] pick
);

    // req/pick bit order: [0]=W, [1]=S, [2]=L
    always_comb begin
        pick = 3'b000;
        unique case (ptr)
            RR_W: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
            RR_S: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            RR_L: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: pick = 3'b000;
        endcase
    end

endmodule

// File: rtl/router_1_out_arbiter.sv
// router_1 per-output wormhole arbiter: locks one input until its tail flit crosses.
module router_1_out_arbiter
    import router_1_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 W_req,
    input  logic                 S_req,
    input  logic                 L_req,
    input  logic                 W_tail,
    input  logic                 S_tail,
    input  logic                 L_tail,
    input  logic                 out_ready,
    output logic [2:0]           sel_out,
    output logic                 W_grant,
    output logic                 S_grant,
    output logic                 L_grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] flit_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_W = 2'd1,
        LOCK_S = 2'd2,
        LOCK_L = 2'd3
    } state_t;

    state_t               state_q, state_d;
    rr_t                  rr_q, rr_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           pick;

    router_1_rr_pick u_pick (
        .req  ({L_req, S_req, W_req}),
        .ptr  (rr_q),
        .pick (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= RR_W;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (W_grant || S_grant || L_grant)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // IDLE never grants: one cycle of arbitration before the first transfer
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_out = PORT_NONE;
        W_grant = 1'b0;
        S_grant = 1'b0;
        L_grant = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick[0]: state_d = LOCK_W;
                    pick[1]: state_d = LOCK_S;
                    pick[2]: state_d = LOCK_L;
                    default: state_d = IDLE;
                endcase
            end
            LOCK_W: begin
                busy    = 1'b1;
                W_grant = W_req & out_ready;
                if (W_grant) sel_out = PORT_W;
                if (W_grant && W_tail) begin
                    state_d = IDLE;
                    rr_d    = rr_after(RR_W);
                end
            end
            LOCK_S: begin
                busy    = 1'b1;
                S_grant = S_req & out_ready;
                if (S_grant) sel_out = PORT_S;
                if (S_grant && S_tail) begin
                    state_d = IDLE;
                    rr_d    = rr_after(RR_S);
                end
            end
            LOCK_L: begin
                busy    = 1'b1;
                L_grant = L_req & out_ready;
                if (L_grant) sel_out = PORT_L;
                if (L_grant && L_tail) begin
                    state_d = IDLE;
                    rr_d    = rr_after(RR_L);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flit_cnt = cnt_q;

endmodule

// File: tb/tb_router_1_out_arbiter.sv
// Self-checking bench for router_1_out_arbiter: directed cases plus random traffic.
module tb_router_1_out_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr = 0, sr = 0, lr = 0, wt = 0, st = 0, lt = 0, rdy = 0;
    logic [2:0]  sel_out, sel4;
    logic        W_grant, S_grant, L_grant, busy;
    logic        wg4, sg4, lg4, busy4;
    logic [15:0] flit_cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    router_1_out_arbiter dut (
        .clk(clk), .rst(rst),
        .W_req(wr), .S_req(sr), .L_req(lr),
        .W_tail(wt), .S_tail(st), .L_tail(lt),
        .out_ready(rdy), .sel_out(sel_out),
        .W_grant(W_grant), .S_grant(S_grant), .L_grant(L_grant),
        .busy(busy), .flit_cnt(flit_cnt)
    );

    router_1_out_arbiter #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .W_req(wr), .S_req(sr), .L_req(lr),
        .W_tail(wt), .S_tail(st), .L_tail(lt),
        .out_ready(rdy), .sel_out(sel4),
        .W_grant(wg4), .S_grant(sg4), .L_grant(lg4),
        .busy(busy4), .flit_cnt(cnt4)
    );

    int errors = 0;
    int checks = 0;

    // Model: lock = -1 idle, else port index 0=W 1=S 2=L
    int lock = -1;
    int ptr = 0;
    int cnt = 0;
    int code[3] = '{3, 4, 0};
    logic [2:0] last_eg;

    logic [2:0] cg, csel;
    logic       cbusy;
    logic [15:0] ccnt;
    logic [3:0]  ccnt4;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        lock = -1;
        ptr = 0;
        cnt = 0;
    endtask

    task automatic model_check();
        logic [2:0] req, tail, eg;
        int es;
        req = {lr, sr, wr};
        tail = {lt, st, wt};
        eg = 3'b000;
        es = 7;
        if (lock >= 0 && req[lock] && rdy) begin
            eg[lock] = 1'b1;
            es = code[lock];
        end
        last_eg = eg;
        chk("grants", int'(cg), int'(eg));
        chk("sel_out", int'(csel), es);
        chk("busy", int'(cbusy), (lock >= 0) ? 1 : 0);
        chk("flit_cnt", int'(ccnt), cnt % 65536);
        chk("flit_cnt4", int'(ccnt4), cnt % 16);
        if (lock < 0) begin
            for (int k = 0; k < 3; k++) begin
                if (req[(ptr + k) % 3]) begin
                    lock = (ptr + k) % 3;
                    break;
                end
            end
        end else if (eg != 3'b000) begin
            cnt++;
            if (tail[lock]) begin
                ptr = (lock + 1) % 3;
                lock = -1;
            end
        end
    endtask

    task automatic cyc(input logic w, s, l, a, b, c, r);
        @(negedge clk);
        wr = w; sr = s; lr = l;
        wt = a; st = b; lt = c;
        rdy = r;
        #1;
        cg = {L_grant, S_grant, W_grant};
        csel = sel_out;
        cbusy = busy;
        ccnt = flit_cnt;
        ccnt4 = cnt4;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        {wr, sr, lr, wt, st, lt, rdy} = '0;
        rst = 1'b1;
        #1;
        chk("rst_sel", int'(sel_out), 7);
        chk("rst_grants", int'({L_grant, S_grant, W_grant}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(flit_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int src_len[3];
    logic [2:0] exp_order[3] = '{3'b001, 3'b010, 3'b100};

    initial begin
        do_reset();

        // single-flit L packet
        cyc(0, 0, 1, 0, 0, 1, 1);
        chk("t1_arb_nogrant", int'(cg), 0);
        cyc(0, 0, 1, 0, 0, 1, 1);
        chk("t1_lgrant", int'(cg), 4);
        chk("t1_sel", int'(csel), 0);
        chk("t1_busy", int'(cbusy), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t1_idle", int'(cbusy), 0);
        chk("t1_cnt", int'(ccnt), 1);
        chk("t1_model_ptr", ptr, 0);

        // W, S, L all requesting single flits
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 1, 1, 1, 1, 1);
            chk("t2_order", int'(cg), (i % 2) ? int'(exp_order[(i / 2) % 3]) : 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t2_cnt6", int'(ccnt), 6);

        // 4-flit W packet while S requests
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, (i == 3), 0, 0, 1);
            chk("t3_wburst", int'(cg), 1);
        end
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("t3_bubble", int'(cg), 0);
        chk("t3_bubble_busy", int'(cbusy), 0);
        cyc(0, 1, 0, 0, 1, 0, 1);
        chk("t3_s_next", int'(cg), 2);

        // out_ready toggling during W packet
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0, (i % 2 == 0));
            chk("t4_grant", int'(cg), (i % 2 == 0) ? 1 : 0);
            chk("t4_sel", int'(csel), (i % 2 == 0) ? 3 : 7);
            chk("t4_busy", int'(cbusy), 1);
        end
        cyc(1, 0, 0, 1, 0, 0, 1);
        chk("t4_tail", int'(cg), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t4_released", int'(cbusy), 0);

        // W_req gap mid-packet while L waits
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 1, 1);
            chk("t5_gap_grant", int'(cg), 0);
            chk("t5_gap_busy", int'(cbusy), 1);
        end
        cyc(1, 0, 1, 1, 0, 1, 1);
        chk("t5_wtail", int'(cg), 1);
        cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 1, 1);
        chk("t5_l_served", int'(cg), 4);

        // async reset mid-packet in LOCK_S
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("t6_cnt5", int'(ccnt), 5);
        rdy = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_sel", int'(sel_out), 7);
        chk("t6_grants", int'({L_grant, S_grant, W_grant}), 0);
        chk("t6_cnt", int'(flit_cnt), 0);
        model_reset();
        {wr, sr, lr, wt, st, lt, rdy} = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 1, 1, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1, 1, 1);
        chk("t6_ptr_w", int'(cg), 1);

        // 4-bit counter wrap after 16 transfers
        do_reset();
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t7_wrap4", int'(ccnt4), 0);
        chk("t7_cnt16", int'(ccnt), 16);

        // random traffic
        do_reset();
        for (int p = 0; p < 3; p++) src_len[p] = $urandom_range(1, 4);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                src_len[0] == 1, src_len[1] == 1, src_len[2] == 1,
                ($urandom % 4) != 0);
            for (int p = 0; p < 3; p++) begin
                if (last_eg[p]) begin
                    src_len[p]--;
                    if (src_len[p] == 0) src_len[p] = $urandom_range(1, 4);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
